// File: rtl/ppi_pkg.sv
// ppi_pkg: definitions shared by the PPI bus master and its phase timer.
//   - state_t       : FSM state encoding
//   - PORT_*/CTRL   : PPI register addresses
//   - CW_*          : control-word field positions (mode-set flag, BSR fields)
//   - T_MIN/T_MAX   : legal range of the phase-length parameters
//   - bsr_word/mode_word : helpers that assemble control words
package ppi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_STROBE  = 3'd2,
      ST_HOLD    = 3'd3,
      ST_RECOVER = 3'd4
   } state_t;

   localparam logic [1:0] PORT_A = 2'd0;
   localparam logic [1:0] PORT_B = 2'd1;
   localparam logic [1:0] PORT_C = 2'd2;
   localparam logic [1:0] CTRL   = 2'd3;

   localparam int CW_MODE_SET_BIT = 7;
   localparam int CW_BSR_SEL_MSB  = 3;
   localparam int CW_BSR_SEL_LSB  = 1;
   localparam int CW_BSR_SR_BIT   = 0;

   localparam int T_MIN   = 1;
   localparam int T_MAX   = 15;
   localparam int TIMER_W = 4;

   // Bit set/reset word for port C: mode-set flag clear.
   function automatic logic [7:0] bsr_word(input logic [2:0] sel, input logic set);
      logic [7:0] w;
      w = '0;
      w[CW_BSR_SEL_MSB:CW_BSR_SEL_LSB] = sel;
      w[CW_BSR_SR_BIT]                 = set;
      return w;
   endfunction

   // Mode-definition word: mode-set flag forced high over the given fields.
   function automatic logic [7:0] mode_word(input logic [6:0] fields);
      logic [7:0] w;
      w = {1'b0, fields};
      w[CW_MODE_SET_BIT] = 1'b1;
      return w;
   endfunction

endpackage

// File: rtl/ppi_phase_timer.sv
// ppi_phase_timer: loadable down-counter that times one bus phase.
//   clk      : clock
//   rst      : synchronous active-high reset
//   load     : load load_val this edge (has priority over counting)
//   load_val : phase length minus one
//   zero     : counter has reached 0, i.e. current cycle is the last of the phase
module ppi_phase_timer
   import ppi_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_val,
   output logic               zero
);

   logic [TIMER_W-1:0] count;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (count != '0)
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/ppi_bus_master.sv
// ppi_bus_master: drives 8255-style PPI bus cycles for single-register
// read/write requests from internal logic.
//   CLK, RST          : clock, synchronous active-high reset
//   REQ, REQ_WR       : request strobe, 1 = write / 0 = read
//   REQ_ADDR, REQ_DATA: target register and write data
//   BUSY, DONE        : transaction in progress, one-cycle completion pulse
//   RD_DATA           : data captured by the last completed read
//   CS, RD, WR        : active-low chip select and strobes
//   A, D_OUT, D_OE    : address, outgoing data and its drive enable
//   D_IN              : data bus as seen at the pad
// Phase lengths T_SETUP / T_STROBE / T_HOLD are in cycles (1..15).
module ppi_bus_master
   import ppi_pkg::*;
#(
   parameter int T_SETUP  = 1,
   parameter int T_STROBE = 2,
   parameter int T_HOLD   = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       REQ,
   input  logic       REQ_WR,
   input  logic [1:0] REQ_ADDR,
   input  logic [7:0] REQ_DATA,
   output logic       BUSY,
   output logic       DONE,
   output logic [7:0] RD_DATA,
   output logic       CS,
   output logic       RD,
   output logic       WR,
   output logic [1:0] A,
   output logic [7:0] D_OUT,
   output logic       D_OE,
   input  logic [7:0] D_IN
);

   if (T_SETUP < T_MIN || T_SETUP > T_MAX ||
       T_STROBE < T_MIN || T_STROBE > T_MAX ||
       T_HOLD < T_MIN || T_HOLD > T_MAX) begin : g_param_check
      $error("ppi_bus_master: phase length parameter outside 1..15");
   end

   localparam logic [TIMER_W-1:0] SETUP_LD  = TIMER_W'(T_SETUP - 1);
   localparam logic [TIMER_W-1:0] STROBE_LD = TIMER_W'(T_STROBE - 1);
   localparam logic [TIMER_W-1:0] HOLD_LD   = TIMER_W'(T_HOLD - 1);

   state_t               state;
   logic                 is_write;
   logic                 phase_last;
   logic                 timer_load;
   logic [TIMER_W-1:0]   timer_val;

   // The timer is reloaded on the same edge that enters each timed phase,
   // so its zero flag marks the last cycle of the phase now running.
   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      timer_load = 1'b0;
      timer_val  = SETUP_LD;
      case (state)
         ST_IDLE: begin
            timer_load = REQ;
            timer_val  = SETUP_LD;
         end
         ST_SETUP: begin
            timer_load = phase_last;
            timer_val  = STROBE_LD;
         end
         ST_STROBE: begin
            timer_load = phase_last;
            timer_val  = HOLD_LD;
         end
         default: ;
      endcase
   end

   ppi_phase_timer u_timer (
      .clk      (CLK),
      .rst      (RST),
      .load     (timer_load),
      .load_val (timer_val),
      .zero     (phase_last)
   );

   // Outputs are registered: each transition sets the bus values that the
   // state being entered must present from the next cycle on.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= ST_IDLE;
         is_write <= 1'b0;
         CS       <= 1'b1;
         RD       <= 1'b1;
         WR       <= 1'b1;
         A        <= PORT_A;
         D_OUT    <= 8'h00;
         D_OE     <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         RD_DATA  <= 8'h00;
      end else begin
         DONE <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (REQ) begin
                  state    <= ST_SETUP;
                  is_write <= REQ_WR;
                  A        <= REQ_ADDR;
                  CS       <= 1'b0;
                  D_OE     <= REQ_WR;
                  BUSY     <= 1'b1;
                  if (REQ_WR)
                     D_OUT <= REQ_DATA;
               end
            end
            ST_SETUP: begin
               if (phase_last) begin
                  state <= ST_STROBE;
                  RD    <= is_write;
                  WR    <= !is_write;
               end
            end
            ST_STROBE: begin
               if (phase_last) begin
                  state <= ST_HOLD;
                  RD    <= 1'b1;
                  WR    <= 1'b1;
                  // RD is still low on this edge, so the PPI is still driving.
                  if (!is_write)
                     RD_DATA <= D_IN;
               end
            end
            ST_HOLD: begin
               if (phase_last) begin
                  state <= ST_RECOVER;
                  CS    <= 1'b1;
                  D_OE  <= 1'b0;
                  DONE  <= 1'b1;
               end
            end
            ST_RECOVER: begin
               state <= ST_IDLE;
               BUSY  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ppi_bus_master.sv
// Bench for ppi_bus_master: two instances (default timing and 3/1/2 timing)
// share one stimulus stream; a cycle-index model predicts every output.
module tb_ppi_bus_master;
   import ppi_pkg::*;

   logic       clk = 1'b0;
   logic       rst, req, req_wr;
   logic [1:0] req_addr;
   logic [7:0] req_data, d_in;

   logic       busy_o [2];
   logic       done_o [2];
   logic       cs_o   [2];
   logic       rd_o   [2];
   logic       wr_o   [2];
   logic       doe_o  [2];
   logic [1:0] a_o    [2];
   logic [7:0] dout_o [2];
   logic [7:0] rdd_o  [2];

   int n_vectors     = 0;
   int n_miscompares = 0;
   bit cmp_en        = 1'b0;

   always #5 clk = ~clk;

   ppi_bus_master #(.T_SETUP(1), .T_STROBE(2), .T_HOLD(1)) u_dut0 (
      .CLK(clk), .RST(rst), .REQ(req), .REQ_WR(req_wr), .REQ_ADDR(req_addr),
      .REQ_DATA(req_data), .BUSY(busy_o[0]), .DONE(done_o[0]), .RD_DATA(rdd_o[0]),
      .CS(cs_o[0]), .RD(rd_o[0]), .WR(wr_o[0]), .A(a_o[0]), .D_OUT(dout_o[0]),
      .D_OE(doe_o[0]), .D_IN(d_in)
   );

   ppi_bus_master #(.T_SETUP(3), .T_STROBE(1), .T_HOLD(2)) u_dut1 (
      .CLK(clk), .RST(rst), .REQ(req), .REQ_WR(req_wr), .REQ_ADDR(req_addr),
      .REQ_DATA(req_data), .BUSY(busy_o[1]), .DONE(done_o[1]), .RD_DATA(rdd_o[1]),
      .CS(cs_o[1]), .RD(rd_o[1]), .WR(wr_o[1]), .A(a_o[1]), .D_OUT(dout_o[1]),
      .D_OE(doe_o[1]), .D_IN(d_in)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vectors++;
      if (act !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int t_setup(input int i);  return (i == 0) ? 1 : 3; endfunction
   function automatic int t_strobe(input int i); return (i == 0) ? 2 : 1; endfunction
   function automatic int t_hold(input int i);   return (i == 0) ? 1 : 2; endfunction

   // Model: k = cycle index since the acceptance edge (0 = idle). The phase
   // in force follows from k by the phase lengths alone.
   int         m_k   [2] = '{0, 0};
   logic       m_wr  [2];
   logic [1:0] m_a   [2];
   logic [7:0] m_dout[2];
   logic [7:0] m_rdd [2];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         automatic int ts  = t_setup(i);
         automatic int tot = t_setup(i) + t_strobe(i) + t_hold(i);
         if (rst) begin
            m_k[i] = 0; m_wr[i] = 1'b0; m_a[i] = 2'd0; m_dout[i] = 8'h00; m_rdd[i] = 8'h00;
         end else if (m_k[i] == 0) begin
            if (req) begin
               m_k[i]  = 1;
               m_wr[i] = req_wr;
               m_a[i]  = req_addr;
               if (req_wr) m_dout[i] = req_data;
            end
         end else begin
            if (m_k[i] == ts + t_strobe(i) && !m_wr[i]) m_rdd[i] = d_in;
            m_k[i] = (m_k[i] == tot + 1) ? 0 : m_k[i] + 1;
         end
      end
   end

   // Compare process: every output of both instances, every cycle.
   always @(negedge clk) begin
      if (cmp_en) begin
         for (int i = 0; i < 2; i++) begin
            automatic int  ts   = t_setup(i);
            automatic int  tst  = t_strobe(i);
            automatic int  tot  = t_setup(i) + t_strobe(i) + t_hold(i);
            automatic bit  act  = (m_k[i] >= 1) && (m_k[i] <= tot);
            automatic bit  strb = (m_k[i] > ts) && (m_k[i] <= ts + tst);
            check($sformatf("cs%0d", i),   cs_o[i],   !act);
            check($sformatf("rd%0d", i),   rd_o[i],   !(strb && !m_wr[i]));
            check($sformatf("wr%0d", i),   wr_o[i],   !(strb && m_wr[i]));
            check($sformatf("doe%0d", i),  doe_o[i],  act && m_wr[i]);
            check($sformatf("busy%0d", i), busy_o[i], m_k[i] != 0);
            check($sformatf("done%0d", i), done_o[i], m_k[i] == tot + 1);
            check($sformatf("a%0d", i),    a_o[i],    m_a[i]);
            check($sformatf("dout%0d", i), dout_o[i], m_dout[i]);
            check($sformatf("rdd%0d", i),  rdd_o[i],  m_rdd[i]);
            check($sformatf("inv%0d", i),
                  !((!rd_o[i] && !wr_o[i]) || (cs_o[i] && (!rd_o[i] || !wr_o[i]))), 1);
         end
      end
   end

   task automatic start(input logic wr, input logic [1:0] addr, input logic [7:0] data);
      req = 1'b1; req_wr = wr; req_addr = addr; req_data = data;
   endtask

   task automatic idle(input int n);
      req = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [7:0] cs_exp, wr_exp, rd_exp, done_exp, doe_exp;
      int dones, windows;
      logic prev_cs;

      rst = 1'b1; req = 1'b0; req_wr = 1'b0; req_addr = 2'd0; req_data = 8'h00; d_in = 8'h00;
      repeat (2) @(negedge clk);
      cmp_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         check("reset_cs", cs_o[i], 1);      check("reset_rd", rd_o[i], 1);
         check("reset_wr", wr_o[i], 1);      check("reset_a", a_o[i], 0);
         check("reset_dout", dout_o[i], 0);  check("reset_doe", doe_o[i], 0);
         check("reset_busy", busy_o[i], 0);  check("reset_done", done_o[i], 0);
         check("reset_rdd", rdd_o[i], 0);
      end
      rst = 1'b0;
      idle(2);

      // Write 0x80 to the control word, default timing.
      cs_exp = 8'b1110_0001; wr_exp = 8'b1111_0011; done_exp = 8'b0010_0000; doe_exp = 8'b0001_1110;
      start(1'b1, CTRL, 8'h80);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         req = 1'b0;
         check("w80_cs", cs_o[0], cs_exp[c]);     check("w80_wr", wr_o[0], wr_exp[c]);
         check("w80_rd", rd_o[0], 1);             check("w80_done", done_o[0], done_exp[c]);
         check("w80_doe", doe_o[0], doe_exp[c]);
         if (doe_exp[c]) begin
            check("w80_a", a_o[0], 3); check("w80_dout", dout_o[0], 8'h80);
         end
      end
      idle(8);

      // Read port B with 0x99 on the bus.
      d_in = 8'h99;
      rd_exp = 8'b1111_0011;
      start(1'b0, PORT_B, 8'h00);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         req = 1'b0;
         check("rd99_rd", rd_o[0], rd_exp[c]);  check("rd99_wr", wr_o[0], 1);
         check("rd99_doe", doe_o[0], 0);        check("rd99_done", done_o[0], c == 5);
         check("rd99_rdd", rdd_o[0], (c >= 4) ? 8'h99 : 8'h00);
      end
      idle(8);

      // REQ held high across three back-to-back writes.
      start(1'b1, PORT_A, 8'h55);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1)  req_data = 8'h99;
         if (c == 7)  req_data = 8'h0F;
         if (c == 13) req = 1'b0;
         check("b2b_done", done_o[0], c == 5 || c == 11 || c == 17);
         if (c == 1)  check("b2b_d1", dout_o[0], 8'h55);
         if (c == 7)  check("b2b_d2", dout_o[0], 8'h99);
         if (c == 13) check("b2b_d3", dout_o[0], 8'h0F);
      end
      idle(10);

      // REQ pulse during STROBE of a read is dropped.
      dones = 0; windows = 0; prev_cs = 1'b1;
      start(1'b0, PORT_C, 8'h00);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         req = (c == 2);
         if (done_o[0]) dones++;
         if (prev_cs && !cs_o[0]) windows++;
         prev_cs = cs_o[0];
      end
      check("ign_dones", dones, 1);
      check("ign_windows", windows, 1);
      idle(4);

      // Reset during STROBE of a read aborts it.
      d_in = 8'hAA;
      start(1'b0, PORT_A, 8'h00);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         req = 1'b0;
         rst = (c == 2);
         if (c == 3) begin
            check("abort_cs", cs_o[0], 1);   check("abort_rd", rd_o[0], 1);
            check("abort_wr", wr_o[0], 1);   check("abort_doe", doe_o[0], 0);
            check("abort_busy", busy_o[0], 0);
         end
         if (c >= 3) begin
            check("abort_done", done_o[0], 0); check("abort_rdd", rdd_o[0], 8'h00);
         end
      end
      idle(4);

      // 3/1/2 timing instance: write 0x0F to the control word.
      start(1'b1, CTRL, 8'h0F);
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         req = 1'b0;
         check("t312_wr", wr_o[1], c != 4);
         check("t312_cs", cs_o[1], !(c >= 1 && c <= 6));
         check("t312_done", done_o[1], c == 7);
         check("t312_rd", rd_o[1], 1);
      end
      idle(4);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 600; n++) begin
         rst      = ($urandom_range(0, 79) == 0);
         req      = ($urandom_range(0, 3) != 0);
         req_wr   = $urandom_range(0, 1) != 0;
         req_addr = 2'($urandom_range(0, 3));
         req_data = (req_addr == CTRL && $urandom_range(0, 1) != 0)
                    ? bsr_word(3'($urandom_range(0, 7)), $urandom_range(0, 1) != 0)
                    : 8'($urandom);
         d_in     = 8'($urandom);
         @(negedge clk);
      end
      rst = 1'b0;
      idle(12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
